// File: rtl/rw_serial_tx.sv
// Serial transmitter for the read/write flow: latches a word from memory or the host buffer,
// sends start/data(LSB first)/stop on SerOut and pulses TxDone. Define RW_SERIAL_TX_PARITY_EN for an even-parity bit.
module rw_serial_tx #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              SampleData,
    input  logic              TxData,
    input  logic              Mode,
    input  logic [DATA_W-1:0] MemData,
    input  logic [DATA_W-1:0] HostData,
    output logic              SerOut,
    output logic              TxDone,
    output logic              TxBusy,
    output logic              Loaded
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(DATA_W + 3);
`ifdef RW_SERIAL_TX_PARITY_EN
    localparam int NBITS = DATA_W + 3;
`else
    localparam int NBITS = DATA_W + 2;
`endif
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
    localparam logic [BIT_W-1:0]  BIT_DLAST = BIT_W'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADED,
        S_SEND,
        S_DONE,
        S_RELEASE
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [BAUD_W-1:0]   baud_q,  baud_d;
    logic [BIT_W-1:0]    bit_q,   bit_d;
    logic                ser_q,   ser_d;
    logic                done_q,  done_d;
    logic                busy_q,  busy_d;
    logic                loaded_q, loaded_d;
`ifdef RW_SERIAL_TX_PARITY_EN
    logic                parity_q, parity_d;
`endif

    logic [DATA_W-1:0] src_word;
    assign src_word = Mode ? MemData : HostData;

    // NOTE: every next-state variable gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        ser_d    = ser_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
        loaded_d = loaded_q;
`ifdef RW_SERIAL_TX_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (SampleData) begin
                    shift_d  = src_word;
                    loaded_d = 1'b1;
                    state_d  = S_LOADED;
                end
            end
            S_LOADED: begin
                if (SampleData) shift_d = src_word;
                if (TxData) begin
                    state_d  = S_SEND;
                    ser_d    = 1'b0;
                    busy_d   = 1'b1;
                    loaded_d = 1'b0;
                    baud_d   = '0;
                    bit_d    = '0;
`ifdef RW_SERIAL_TX_PARITY_EN
                    parity_d = ^shift_d;
`endif
                end
            end
            S_SEND: begin
                if (!TxData) begin
                    state_d = S_IDLE;
                    ser_d   = 1'b1;
                    busy_d  = 1'b0;
                    baud_d  = '0;
                    bit_d   = '0;
                end else if (baud_q != BAUD_LAST) begin
                    baud_d = baud_q + 1'b1;
                end else if (bit_q == BIT_LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ser_d   = 1'b1;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    // bit_q is the index just finished; pick the level of the next one
                    baud_d = '0;
                    bit_d  = bit_q + 1'b1;
                    if (bit_q < BIT_DLAST) begin
                        ser_d   = shift_q[0];
                        shift_d = shift_q >> 1;
`ifdef RW_SERIAL_TX_PARITY_EN
                    end else if (bit_q == BIT_DLAST) begin
                        ser_d = parity_q;
`endif
                    end else begin
                        ser_d = 1'b1;
                    end
                end
            end
            S_DONE:    state_d = TxData ? S_RELEASE : S_IDLE;
            S_RELEASE: if (!TxData) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // NOTE: the shift register is reset along with control state so no stale word leaks after Reset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            ser_q    <= 1'b1;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
            loaded_q <= 1'b0;
`ifdef RW_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            state_q  <= state_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            ser_q    <= ser_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            loaded_q <= loaded_d;
`ifdef RW_SERIAL_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign SerOut = ser_q;
    assign TxDone = done_q;
    assign TxBusy = busy_q;
    assign Loaded = loaded_q;

endmodule

// File: tb/tb_rw_serial_tx.sv
// Scoreboard bench for rw_serial_tx: stimulus pushes expected line levels and completion latency,
// a negedge monitor pops and compares them against SerOut/TxDone.
module tb_rw_serial_tx;

    localparam int DATA_W  = 8;
    localparam int CLK_DIV = 4;
`ifdef RW_SERIAL_TX_PARITY_EN
    localparam int F = (DATA_W + 3) * CLK_DIV;
`else
    localparam int F = (DATA_W + 2) * CLK_DIV;
`endif

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              SampleData = 1'b0;
    logic              TxData = 1'b0;
    logic              Mode = 1'b0;
    logic [DATA_W-1:0] MemData = '0;
    logic [DATA_W-1:0] HostData = '0;
    logic              SerOut, TxDone, TxBusy, Loaded;

    rw_serial_tx #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .SampleData (SampleData),
        .TxData     (TxData),
        .Mode       (Mode),
        .MemData    (MemData),
        .HostData   (HostData),
        .SerOut     (SerOut),
        .TxDone     (TxDone),
        .TxBusy     (TxBusy),
        .Loaded     (Loaded)
    );

    always #5 Clk = ~Clk;

    int                n_vec = 0;
    int                n_err = 0;
    logic              exp_ser_q[$];
    int                exp_done_q[$];
    int                busy_cnt = 0;
    logic [DATA_W-1:0] model_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB first, optional even parity, stop; each level CLK_DIV cycles.
    function automatic void push_frame(input logic [DATA_W-1:0] w, input int n);
        logic bits[$];
        int   cnt = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DATA_W; i++) bits.push_back(w[i]);
`ifdef RW_SERIAL_TX_PARITY_EN
        bits.push_back(^w);
`endif
        bits.push_back(1'b1);
        foreach (bits[b])
            for (int r = 0; r < CLK_DIV; r++)
                if (cnt < n) begin
                    exp_ser_q.push_back(bits[b]);
                    cnt++;
                end
    endfunction

    always @(negedge Clk) begin
        if (TxBusy) begin
            busy_cnt++;
            if (exp_ser_q.size() == 0) check("unexpected_busy", TxBusy, 0);
            else begin
                check("serout", SerOut, exp_ser_q.pop_front());
                check("busy_loaded", Loaded, 0);
            end
        end else begin
            check("idle_line", SerOut, 1);
        end
        if (TxDone) begin
            if (exp_done_q.size() == 0) check("unexpected_done", TxDone, 0);
            else check("done_latency", busy_cnt, exp_done_q.pop_front());
        end
        if (!TxBusy) busy_cnt = 0;
    end

    task automatic load(input logic m, input logic [DATA_W-1:0] mem, input logic [DATA_W-1:0] host);
        SampleData = 1'b1;
        Mode       = m;
        MemData    = mem;
        HostData   = host;
        model_word = m ? mem : host;
        @(posedge Clk); #1 SampleData = 1'b0;
        check("loaded", Loaded, 1);
    endtask

    task automatic send_frame(input bit sim_load, input logic [DATA_W-1:0] sim_word,
                              input int hold, input bit noise);
        if (sim_load) begin
            SampleData = 1'b1;
            Mode       = 1'b1;
            MemData    = sim_word;
            model_word = sim_word;
        end
        push_frame(model_word, F);
        exp_done_q.push_back(F);
        TxData = 1'b1;
        @(posedge Clk); #1 SampleData = 1'b0;
        for (int i = 1; i <= F; i++) begin
            if (noise && i == 3) begin
                SampleData = 1'b1;
                MemData    = DATA_W'($urandom);
                HostData   = DATA_W'($urandom);
            end
            @(posedge Clk); #1 SampleData = 1'b0;
        end
        check("done_loaded", Loaded, 0);
        for (int j = 0; j < hold; j++) begin
            if (noise && j == 1) SampleData = 1'b1;
            @(posedge Clk); #1 SampleData = 1'b0;
        end
        TxData = 1'b0;
        repeat (2) @(posedge Clk);
        #1 check("idle_loaded", Loaded, 0);
    endtask

    task automatic abort_frame(input int k);
        push_frame(model_word, k);
        TxData = 1'b1;
        repeat (k) @(posedge Clk);
        #1 TxData = 1'b0;
        @(posedge Clk); #1;
        check("abort_ser", SerOut, 1);
        check("abort_busy", TxBusy, 0);
        check("abort_loaded", Loaded, 0);
        check("abort_done", TxDone, 0);
        repeat (2) @(posedge Clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #7;
        check("rst_ser", SerOut, 1);
        check("rst_done", TxDone, 0);
        check("rst_busy", TxBusy, 0);
        check("rst_loaded", Loaded, 0);
        #5 Reset = 1'b0;
        @(posedge Clk); #1;

        // Directed frames, the first one held past TxDone
        load(1'b1, 8'hA5, 8'h00);
        send_frame(1'b0, '0, 5, 1'b0);
        load(1'b0, 8'hFF, 8'h3C);
        send_frame(1'b0, '0, 0, 1'b0);

        // Abort in cycle 13 of an all-ones frame
        load(1'b1, 8'hFF, 8'h00);
        abort_frame(13);

        // Asynchronous reset while a zero data bit is on the line
        load(1'b1, 8'h00, 8'h00);
        push_frame(8'h00, 9);
        TxData = 1'b1;
        repeat (10) @(posedge Clk);
        #1 check("pre_reset_ser", SerOut, 0);
        #1 Reset = 1'b1;
        #1;
        check("async_rst_ser", SerOut, 1);
        check("async_rst_busy", TxBusy, 0);
        check("async_rst_done", TxDone, 0);
        check("async_rst_loaded", Loaded, 0);
        @(posedge Clk); #1 Reset = 1'b0;
        repeat (20) @(posedge Clk);
        #1;
        check("post_rst_busy", TxBusy, 0);
        check("post_rst_loaded", Loaded, 0);
        TxData = 1'b0;
        @(posedge Clk); #1;

        // Reload wins, then simultaneous load and transmit
        load(1'b1, 8'h11, 8'h00);
        load(1'b1, 8'h22, 8'h00);
        send_frame(1'b0, '0, 0, 1'b0);
        load(1'b1, 8'h11, 8'h00);
        send_frame(1'b1, 8'h80, 1, 1'b0);
        load(1'b1, 8'h07, 8'h00);
        send_frame(1'b0, '0, 2, 1'b1);

        for (int t = 0; t < 14; t++) begin
            int nl;
            nl = $urandom_range(1, 2);
            for (int l = 0; l < nl; l++)
                load(1'($urandom), DATA_W'($urandom), DATA_W'($urandom));
            if ($urandom_range(0, 3) == 0) abort_frame($urandom_range(1, F - 1));
            else send_frame(1'($urandom), DATA_W'($urandom), $urandom_range(0, 3), 1'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge Clk);
            #1;
        end

        repeat (5) @(posedge Clk);
        #1;
        check("ser_queue_drained", exp_ser_q.size(), 0);
        check("done_queue_drained", exp_done_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rw_serial_tx.md
Name: rw_serial_tx

Overview:
- Serial transmitter at the far end of the read/write control flow: consumes the SampleData / TxData strobes from the flow controller and returns TxDone.
- Latches a parallel word from memory read data (Mode=1) or the host serial buffer (Mode=0).
- Sends the word as an asynchronous frame on SerOut: start bit, data LSB first, stop bit.
- Provides the TxDone completion pulse that releases the controller from its wait state.

Parameters:
- DATA_W, 8, data word width in bits (>=2).
- CLK_DIV, 4, Clk cycles per serial bit (>=2).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  reset.
- SampleData  in  1  load strobe; captures the source word.
- TxData  in  1  transmit request, level; held high for the whole frame.
- Mode  in  1  source select: 1 = MemData, 0 = HostData.
- MemData  in  DATA_W  memory read data.
- HostData  in  DATA_W  host serial buffer word.
- SerOut  out  1  serial line; idle high.
- TxDone  out  1  one-cycle pulse after the stop bit completes.
- TxBusy  out  1  high while a frame is on the line.
- Loaded  out  1  shift register holds a word not yet sent.

Behaviour:
- Clocking and reset: reset Reset, asynchronous, active-high; clock Clk. All state is updated on posedge Clk.
- Reset values: SerOut=1, TxDone=0, TxBusy=0, Loaded=0, state=IDLE, baud and bit counters 0.
- Reset mid-frame: SerOut returns to 1 immediately (asynchronous). No TxDone is produced.
- Outputs are registered.
- States: IDLE, LOADED, SEND, DONE, RELEASE.
- IDLE:
  - SampleData=1 latches (Mode ? MemData : HostData) into the shift register, then goes to LOADED with Loaded=1.
  - TxData is ignored in IDLE; nothing to send.
- LOADED:
  - SampleData=1 reloads the shift register (last load wins).
  - TxData=1 goes to SEND. At the same edge: SerOut=0 (start bit), TxBusy=1, Loaded=0, counters cleared.
  - If SampleData and TxData are both high at the same edge, the reload happens and the new word is sent.
- SEND:
  - Each bit holds SerOut for exactly CLK_DIV cycles; baud counter runs 0..CLK_DIV-1.
  - Bit order: start(0), D[0]..D[DATA_W-1], stop(1).
  - Frame length F = (DATA_W+2)*CLK_DIV cycles.
  - SampleData is ignored during SEND.
  - TxData=0 at any edge in SEND aborts: SerOut=1, TxBusy=0, go to IDLE, no TxDone.
- DONE:
  - Entered at the edge ending the last stop-bit cycle, i.e. F cycles after SerOut first went 0.
  - TxDone=1 for exactly this one cycle; TxBusy=0; SerOut=1.
  - Next state is RELEASE if TxData=1, else IDLE.
- RELEASE:
  - Waits for TxData=0, then goes to IDLE.
  - Blocks re-transmission while the controller still holds TxData after TxDone.
  - SampleData is ignored until IDLE.
- TxDone is 0 in every state except DONE, so the controller's TxDone==0 checks pass before completion.
- Counter widths: ceil(log2(CLK_DIV)) bits for the baud counter, ceil(log2(DATA_W+3)) bits for the bit counter. Neither wraps past its terminal count.

Optional Feature:
- Macro: RW_SERIAL_TX_PARITY_EN.
- Defined: an even-parity bit (XOR of the data bits) is sent after D[DATA_W-1] and before stop. F = (DATA_W+3)*CLK_DIV. TxDone timing shifts accordingly.
- Undefined: no parity bit. Frame exactly as described above.

Test Plan:
- DATA_W=8, CLK_DIV=4, Mode=1, MemData=0xA5: SampleData pulse, then TxData held high.
  - SerOut = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles.
  - TxDone one-cycle pulse 40 cycles after the start bit began. TxBusy high for those 40 cycles.
- Same run with TxData still high for 5 more cycles after TxDone: no second frame, SerOut stays 1. After TxData drops, a new SampleData with Mode=0, HostData=0x3C sends 0,0,0,1,1,1,1,0,0,1.
- Abort: TxData dropped in cycle 13 of a 0xFF frame. SerOut=1 at the next edge, TxBusy=0, TxDone never asserts, Loaded=0.
- Reset asserted mid-data-bit with SerOut=0: SerOut=1 asynchronously, all outputs at reset values. TxData=1 after reset produces no frame until a SampleData.
- Reload and simultaneous events:
  - SampleData with 0x11, then SampleData with 0x22 in LOADED, then TxData: frame carries 0x22.
  - SampleData and TxData in the same LOADED cycle with MemData=0x80: frame carries 0x80.
- With RW_SERIAL_TX_PARITY_EN, data 0xA5: parity bit 0 precedes stop, TxDone at 44 cycles. With data 0x07: parity bit 1.
